// File: rtl/param_mem.sv
// param_mem: parameterised single-port register memory with a background
// clear sweep that rewrites every word to INIT_VAL, one word per cycle.
module param_mem #(
    parameter int unsigned         DATA_W   = 8,
    parameter int unsigned         ADDR_W   = 6,
    parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_rq,
    input  logic              read_rq,
    input  logic              write_rq,
    input  logic [ADDR_W-1:0] rw_address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              busy,
    output logic              clear_done,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  count;
    logic [ADDR_W-1:0]  count_next;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               rd_en;
    logic               err_next;
    logic               last_word;

    // Sweep is on its final word when the counter reaches the top address.
    assign last_word = (count == LAST_ADDR);

    // Status flags decoded straight from the FSM state and sweep counter.
    assign busy       = (state == CLEAR);
    assign clear_done = (state == CLEAR) && last_word;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a clear request starts the sweep, the last word ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_rq) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath decode: selects the memory write source, read enable,
    // error pulse and next sweep counter for the current state.
    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = rw_address;
        wr_data    = write_data;
        rd_en      = 1'b0;
        err_next   = 1'b0;
        count_next = count;
        case (state)
            IDLE: begin
                if (clear_rq) begin
                    // Same-cycle accesses are silently dropped when a clear starts.
                    count_next = '0;
                end else if (read_rq && write_rq) begin
                    err_next = 1'b1;
                end else if (write_rq) begin
                    wr_en = 1'b1;
                end else if (read_rq) begin
                    rd_en = 1'b1;
                end
            end
            CLEAR: begin
                wr_en      = 1'b1;
                wr_addr    = count;
                wr_data    = INIT_VAL;
                count_next = count + ADDR_W'(1);
                err_next   = read_rq || write_rq;
            end
            default: begin
                count_next = '0;
            end
        endcase
    end

    // Storage array; reset loads every word with INIT_VAL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VAL;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Sweep counter; wraps naturally to zero after the last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Registered read port: read_data holds until the next accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_en;
            if (rd_en) begin
                read_data <= mem[rw_address];
            end
        end
    end

    // Registered one-cycle error pulse for rejected requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end

endmodule

// File: tb/tb_param_mem.sv
// Self-checking bench for param_mem: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the memory.
module tb_param_mem;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst;
    logic        clear_rq;
    logic        read_rq;
    logic        write_rq;
    logic [5:0]  rw_address;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        read_valid;
    logic        busy;
    logic        clear_done;
    logic        err;

    logic        w_clear_rq;
    logic        w_read_rq;
    logic        w_write_rq;
    logic [3:0]  w_rw_address;
    logic [15:0] w_write_data;
    logic [15:0] w_read_data;
    logic        w_read_valid;
    logic        w_busy;
    logic        w_clear_done;
    logic        w_err;

    int checks = 0;
    int passed = 0;

    // Behavioural model: word contents plus the number of sweep writes remaining.
    logic [7:0] m_mem [DEPTH];
    int         m_clear_left;
    logic [7:0] m_rd;
    logic       m_rv;
    logic       m_err;

    param_mem dut (
        .clk        (clk),
        .rst        (rst),
        .clear_rq   (clear_rq),
        .read_rq    (read_rq),
        .write_rq   (write_rq),
        .rw_address (rw_address),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .busy       (busy),
        .clear_done (clear_done),
        .err        (err)
    );

    param_mem #(.DATA_W(16), .ADDR_W(4), .INIT_VAL(16'hBEEF)) dut_wide (
        .clk        (clk),
        .rst        (rst),
        .clear_rq   (w_clear_rq),
        .read_rq    (w_read_rq),
        .write_rq   (w_write_rq),
        .rw_address (w_rw_address),
        .write_data (w_write_data),
        .read_data  (w_read_data),
        .read_valid (w_read_valid),
        .busy       (w_busy),
        .clear_done (w_clear_done),
        .err        (w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_clear_left = 0;
        m_rd  = 8'h00;
        m_rv  = 1'b0;
        m_err = 1'b0;
    endtask

    // Apply one request for one clock, then advance the model by the same rules.
    task automatic tick(input logic r, input logic w, input logic c,
                        input logic [5:0] a, input logic [7:0] d);
        read_rq    = r;
        write_rq   = w;
        clear_rq   = c;
        rw_address = a;
        write_data = d;
        @(posedge clk);
        #1;
        m_rv  = 1'b0;
        m_err = 1'b0;
        if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = 8'h00;
            m_clear_left = m_clear_left - 1;
            m_err = r | w;
        end else if (c) begin
            m_clear_left = DEPTH;
        end else if (r && w) begin
            m_err = 1'b1;
        end else if (w) begin
            m_mem[a] = d;
        end else if (r) begin
            m_rd = m_mem[a];
            m_rv = 1'b1;
        end
        read_rq  = 1'b0;
        write_rq = 1'b0;
        clear_rq = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({read_valid, err, busy, clear_done, read_data} !== 12'h000)
            $display("FAIL reset_outputs: got %h expected %h",
                     {read_valid, err, busy, clear_done, read_data}, 12'h000);
        else passed++;
        tick(1, 0, 0, 6'h2A, 8'h00);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 8'h00)
            $display("FAIL read_after_reset: got rv=%b rd=%h expected rv=1 rd=00",
                     read_valid, read_data);
        else passed++;
        tick(0, 0, 0, 6'h00, 8'h00);
        checks++;
        if (read_valid !== 1'b0)
            $display("FAIL read_valid_single: got %b expected 0", read_valid);
        else passed++;
    endtask

    task automatic test_write_read();
        logic [5:0] others [3];
        tick(0, 1, 0, 6'h3F, 8'hA5);
        checks++;
        if (read_valid !== 1'b0 || err !== 1'b0)
            $display("FAIL write_no_pulse: got rv=%b err=%b expected 0 0", read_valid, err);
        else passed++;
        tick(1, 0, 0, 6'h3F, 8'h00);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 8'hA5)
            $display("FAIL read_3f: got rv=%b rd=%h expected rv=1 rd=a5", read_valid, read_data);
        else passed++;
        others[0] = 6'h00; others[1] = 6'h3E; others[2] = 6'h1F;
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, others[i], 8'h00);
            checks++;
            if (read_data !== 8'h00)
                $display("FAIL read_other_%0h: got %h expected 00", others[i], read_data);
            else passed++;
        end
    endtask

    task automatic test_conflict();
        tick(0, 1, 0, 6'h05, 8'h11);
        tick(1, 0, 0, 6'h3F, 8'h00);
        tick(1, 1, 0, 6'h05, 8'h77);
        checks++;
        if (err !== 1'b1 || read_valid !== 1'b0 || read_data !== 8'hA5)
            $display("FAIL conflict: got err=%b rv=%b rd=%h expected err=1 rv=0 rd=a5",
                     err, read_valid, read_data);
        else passed++;
        tick(1, 0, 0, 6'h05, 8'h00);
        checks++;
        if (err !== 1'b0 || read_valid !== 1'b1 || read_data !== 8'h11)
            $display("FAIL conflict_after: got err=%b rv=%b rd=%h expected err=0 rv=1 rd=11",
                     err, read_valid, read_data);
        else passed++;
    endtask

    task automatic test_clear();
        int busy_cycles;
        int done_at;
        int err_seen;
        int bad_words;
        for (int i = 0; i < DEPTH; i++) tick(0, 1, 0, 6'(i), 8'(i + 1));
        tick(1, 0, 0, 6'h10, 8'h00);
        checks++;
        if (read_data !== 8'h11)
            $display("FAIL fill_check: got %h expected 11", read_data);
        else passed++;
        // Clear with a same-cycle write that must be dropped silently.
        tick(0, 1, 1, 6'h00, 8'hFF);
        busy_cycles = 0;
        done_at = -1;
        err_seen = 0;
        checks++;
        if (err !== 1'b0)
            $display("FAIL clear_start_err: got %b expected 0", err);
        else passed++;
        while (busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            if (clear_done === 1'b1) begin
                if (done_at < 0) done_at = busy_cycles;
                else done_at = 1000;
            end
            if (busy_cycles == 10) tick(0, 1, 0, 6'h02, 8'h99);
            else if (busy_cycles == 30) tick(0, 0, 1, 6'h00, 8'h00);
            else tick(0, 0, 0, 6'h00, 8'h00);
            if (busy_cycles == 10 && err === 1'b1) err_seen++;
            if (busy_cycles == 30 && err === 1'b1) err_seen += 10;
            if (busy_cycles == 11 && err !== 1'b0) err_seen += 100;
        end
        checks++;
        if (busy_cycles != DEPTH)
            $display("FAIL clear_busy_len: got %0d expected %0d", busy_cycles, DEPTH);
        else passed++;
        checks++;
        if (done_at != DEPTH)
            $display("FAIL clear_done_cycle: got %0d expected %0d", done_at, DEPTH);
        else passed++;
        checks++;
        if (err_seen != 1)
            $display("FAIL clear_err_pulses: got code %0d expected 1", err_seen);
        else passed++;
        bad_words = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, 0, 0, 6'(i), 8'h00);
            if (read_valid !== 1'b1 || read_data !== m_mem[i]) bad_words++;
        end
        checks++;
        if (bad_words != 0)
            $display("FAIL clear_contents: got %0d bad words expected 0", bad_words);
        else passed++;
    endtask

    task automatic test_reset_mid_clear();
        int bad_words;
        for (int i = 0; i < 8; i++) tick(0, 1, 0, 6'(i * 7), 8'hC0 + 8'(i));
        tick(0, 0, 1, 6'h00, 8'h00);
        repeat (20) tick(0, 0, 0, 6'h00, 8'h00);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || clear_done !== 1'b0)
            $display("FAIL reset_mid_busy: got busy=%b done=%b expected 0 0", busy, clear_done);
        else passed++;
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick(1, 0, 0, 6'h07, 8'h00);
        checks++;
        if (read_valid !== 1'b1 || read_data !== 8'h00 || busy !== 1'b0)
            $display("FAIL first_edge_after_reset: got rv=%b rd=%h busy=%b expected 1 00 0",
                     read_valid, read_data, busy);
        else passed++;
        bad_words = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, 0, 0, 6'(i), 8'h00);
            if (read_data !== 8'h00) bad_words++;
        end
        checks++;
        if (bad_words != 0)
            $display("FAIL reset_mid_contents: got %0d bad words expected 0", bad_words);
        else passed++;
    endtask

    task automatic test_random();
        int bad;
        logic [11:0] got;
        logic [11:0] exp_v;
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            logic r, w, c;
            r = ($urandom_range(0, 99) < 45);
            w = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 2);
            tick(r, w, c, 6'($urandom), 8'($urandom));
            got   = {read_valid, err, busy, clear_done, read_data};
            exp_v = {m_rv, m_err, (m_clear_left > 0), (m_clear_left == 1), m_rd};
            checks++;
            if (got !== exp_v) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle_%0d: got %h expected %h", n, got, exp_v);
            end else passed++;
        end
    endtask

    task automatic test_wide();
        int busy_cycles;
        w_read_rq = 1'b1;
        w_rw_address = 4'hF;
        @(posedge clk);
        #1;
        w_read_rq = 1'b0;
        checks++;
        if (w_read_valid !== 1'b1 || w_read_data !== 16'hBEEF)
            $display("FAIL wide_read_init: got rv=%b rd=%h expected 1 beef", w_read_valid, w_read_data);
        else passed++;
        w_write_rq = 1'b1;
        w_rw_address = 4'h3;
        w_write_data = 16'h1234;
        @(posedge clk);
        #1;
        w_write_rq = 1'b0;
        w_clear_rq = 1'b1;
        @(posedge clk);
        #1;
        w_clear_rq = 1'b0;
        busy_cycles = 0;
        while (w_busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy_cycles != 16)
            $display("FAIL wide_clear_len: got %0d expected 16", busy_cycles);
        else passed++;
        w_read_rq = 1'b1;
        w_rw_address = 4'h3;
        @(posedge clk);
        #1;
        w_read_rq = 1'b0;
        checks++;
        if (w_read_data !== 16'hBEEF)
            $display("FAIL wide_after_clear: got %h expected beef", w_read_data);
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        clear_rq = 1'b0; read_rq = 1'b0; write_rq = 1'b0;
        rw_address = '0; write_data = '0;
        w_clear_rq = 1'b0; w_read_rq = 1'b0; w_write_rq = 1'b0;
        w_rw_address = '0; w_write_data = '0;
        test_reset();
        test_write_read();
        test_conflict();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/param_mem.md
PARAM_MEM -- requirements
Module: param_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter INIT_VAL, default 0, value (DATA_W bits) loaded into every word by reset and by clear.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_rq  input  1  request to sweep all words to INIT_VAL.
REQ-007 SHALL have port read_rq  input  1  read request.
REQ-008 SHALL have port write_rq  input  1  write request.
REQ-009 SHALL have port rw_address  input  ADDR_W  read/write word address.
REQ-010 SHALL have port write_data  input  DATA_W  write data.
REQ-011 SHALL have port read_data  output  DATA_W  registered read data.
REQ-012 SHALL have port read_valid  output  1  one-cycle pulse, read_data updated this cycle.
REQ-013 SHALL have port busy  output  1  high while clear sweep in progress.
REQ-014 SHALL have port clear_done  output  1  one-cycle pulse on last clear-sweep write.
REQ-015 SHALL have port err  output  1  one-cycle pulse flagging a rejected request.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, CLEAR.
REQ-017 In IDLE with clear_rq=1: SHALL enter CLEAR next edge, load sweep counter to 0, drop any same-cycle read/write without err.
REQ-018 In IDLE with write_rq=1, read_rq=0, clear_rq=0: SHALL write write_data to word rw_address on the rising edge.
REQ-019 In IDLE with read_rq=1, write_rq=0, clear_rq=0: SHALL load read_data with word rw_address on the rising edge and assert read_valid for exactly that following cycle (latency 1).
REQ-020 In IDLE with read_rq=1 and write_rq=1 (clear_rq=0): SHALL perform neither access, leave memory and read_data unchanged, and pulse err for one cycle.
REQ-021 read_data SHALL hold its last value when no read is performed; read_valid SHALL be 0 in every cycle not following an accepted read.
REQ-022 Read of an address written on the previous edge SHALL return the new data; no same-cycle bypass is required.
REQ-023 In CLEAR: SHALL write INIT_VAL to word[counter] each cycle, increment counter (ADDR_W bits), busy=1.
REQ-024 CLEAR SHALL last exactly DEPTH cycles; on the cycle writing word DEPTH-1, clear_done=1, counter wraps to 0, and the FSM returns to IDLE on that edge.
REQ-025 In CLEAR, read_rq or write_rq SHALL be ignored and pulse err for one cycle; clear_rq SHALL be ignored without err (no restart).
REQ-026 busy SHALL be combinational from state (1 iff CLEAR); first IDLE cycle after sweep SHALL accept requests.
REQ-027 Address input SHALL be taken full-width; no out-of-range case exists (DEPTH = 2**ADDR_W).

Reset
REQ-028 On rst=0, asynchronously: all DEPTH words = INIT_VAL, read_data=0, read_valid=0, busy=0, clear_done=0, err=0, counter=0, state IDLE.
REQ-029 Reset asserted mid-CLEAR SHALL abort the sweep; after release FSM SHALL be in IDLE with all words INIT_VAL.
REQ-030 First rising edge after rst release SHALL accept a request normally.

Verification
REQ-031 Reset, then read addr 0x2A -> next cycle read_data=0x00, read_valid=1 for one cycle only.
REQ-032 Write 0xA5 to 0x3F, next cycle read 0x3F -> read_data=0xA5, read_valid=1; other addresses still 0x00.
REQ-033 read_rq=1 and write_rq=1 at 0x05, data 0x77 -> err pulse 1 cycle, read_valid=0, subsequent read 0x05 returns prior value.
REQ-034 Fill all 64 words with address+1, clear_rq 1 cycle -> busy=1 for exactly 64 cycles, clear_done on 64th, write attempts during sweep pulse err, afterwards every word reads 0x00.
REQ-035 Assert rst at sweep cycle 20 -> busy=0 immediately, all words 0x00, read at first edge after release gives read_valid=1.
REQ-036 Instance DATA_W=16, ADDR_W=4, INIT_VAL=0xBEEF: reset then read 0xF -> 0xBEEF; clear sweep lasts 16 cycles.
